// File: rtl/snow3g_pkg.sv
// Shared definitions for the SNOW 3G keystream cipher datapath: word width,
// controller state encoding and the final-word tail mask helper.
package snow3g_pkg;

   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } state_e;

   // Keeps the first 'rem' message bits (MSB-first) of the final word.
   // rem == 0 means the final word is full, so nothing is masked.
   function automatic logic [WORD_W-1:0] last_word_mask(input logic [4:0] rem);
      logic [WORD_W-1:0] mask;
      if (rem == 5'd0) begin
         mask = '1;
      end else begin
         mask = ~({WORD_W{1'b1}} >> rem);
      end
      return mask;
   endfunction

endpackage

// File: rtl/snow3g_ks_cipher_if.sv
// Stream interface of the keystream cipher: message control, keystream and
// data input streams, processed output stream and status.
interface snow3g_ks_cipher_if #(
   parameter int unsigned LEN_W = 16
);
   import snow3g_pkg::*;

   logic              start;
   logic [LEN_W-1:0]  msg_len;
   logic [WORD_W-1:0] ks_word;
   logic              ks_valid;
   logic              ks_ready;
   logic [WORD_W-1:0] din;
   logic              din_valid;
   logic              din_ready;
   logic [WORD_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;
   logic              dout_last;
   logic              busy;
   logic              done;

   // Producer/consumer side driving the cipher
   modport master (
      output start, msg_len, ks_word, ks_valid, din, din_valid, dout_ready,
      input  ks_ready, din_ready, dout, dout_valid, dout_last, busy, done
   );

   // Cipher side
   modport slave (
      input  start, msg_len, ks_word, ks_valid, din, din_valid, dout_ready,
      output ks_ready, din_ready, dout, dout_valid, dout_last, busy, done
   );

endinterface

// File: rtl/snow3g_ks_fifo.sv
// Small keystream prefetch FIFO (synchronous reset plus flush).
// Only built when SNOW3G_KS_PREFETCH_EN is defined; the default build has no
// use for it.
`ifdef SNOW3G_KS_PREFETCH_EN
module snow3g_ks_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [Width-1:0] i_data,
   input  logic             i_pop,
   output logic [Width-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned PtrW = $clog2(Depth);

   logic [Width-1:0] r_mem [Depth];
   logic [PtrW-1:0]  r_wr_ptr;
   logic [PtrW-1:0]  r_rd_ptr;
   logic [PtrW:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_count == (PtrW+1)'(Depth));
   assign o_empty = (r_count == '0);
   assign o_data  = r_mem[r_rd_ptr];

   // Storage; no reset needed since the occupancy count gates every read
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy tracking; flush drops all held words
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PtrW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PtrW'(1);
         end
         r_count <= r_count + (PtrW+1)'(w_push) - (PtrW+1)'(w_pop);
      end
   end

endmodule
`endif

// File: rtl/snow3g_ks_cipher.sv
// SNOW 3G keystream cipher datapath: XORs keystream words onto a message of
// programmable bit length, zero-masks the unused tail of the final word and
// pulses done after the final word has been accepted downstream.
// Optional build macro: SNOW3G_KS_PREFETCH_EN adds a 4-entry keystream FIFO
// so the generator can run ahead of the message data.
module snow3g_ks_cipher #(
   parameter int unsigned LEN_W  = 16,
   parameter int unsigned WORD_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   snow3g_ks_cipher_if.slave   io_bus
);
   import snow3g_pkg::*;

   // Word counter wide enough for ceil((2^LEN_W-1)/32)
   localparam int unsigned CNT_W = LEN_W - 4;

   state_e            r_state;
   state_e            w_state_d;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_nwords;
   logic [4:0]        r_rem;
   logic [WORD_W-1:0] r_dout;
   logic              r_dout_valid;
   logic              r_dout_last;

   logic [CNT_W-1:0]  w_nwords_new;
   logic              w_ks_avail;
   logic [WORD_W-1:0] w_ks_data;
   logic              w_space;
   logic              w_fire;
   logic              w_is_last;
   logic [WORD_W-1:0] w_word;
   logic [WORD_W-1:0] w_out;
   logic              w_flush;

   // ceil(msg_len/32) computed one bit wider so the +31 cannot overflow
   assign w_nwords_new = CNT_W'(({1'b0, io_bus.msg_len} + (LEN_W+1)'(31)) >> 5);

   // Keystream excess is discarded when the message completes
   assign w_flush = (w_state_d == StDone) && (r_state != StDone);

`ifdef SNOW3G_KS_PREFETCH_EN
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [WORD_W-1:0] w_fifo_data;

   snow3g_ks_fifo #(
      .Depth (4),
      .Width (WORD_W)
   ) u_ks_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_flush),
      .i_push  (io_bus.ks_valid),
      .i_data  (io_bus.ks_word),
      .i_pop   (w_fire),
      .o_data  (w_fifo_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   assign w_ks_avail      = !w_fifo_empty;
   assign w_ks_data       = w_fifo_data;
   assign io_bus.ks_ready = !w_fifo_full;
`else
   logic w_unused_flush;

   assign w_unused_flush  = w_flush;
   assign w_ks_avail      = io_bus.ks_valid;
   assign w_ks_data       = io_bus.ks_word;
   // Keystream and data are only ever consumed as a pair
   assign io_bus.ks_ready = w_fire;
`endif

   assign w_space   = !r_dout_valid || io_bus.dout_ready;
   assign w_fire    = !rst && (r_state == StRun) && w_ks_avail && io_bus.din_valid && w_space;
   assign w_is_last = (r_cnt == (r_nwords - CNT_W'(1)));
   assign w_word    = io_bus.din ^ w_ks_data;
   assign w_out     = w_is_last ? (w_word & last_word_mask(r_rem)) : w_word;

   assign io_bus.din_ready  = w_fire;
   assign io_bus.dout       = r_dout;
   assign io_bus.dout_valid = r_dout_valid;
   assign io_bus.dout_last  = r_dout_last;
   assign io_bus.busy       = (r_state == StRun) || (r_state == StDrain);
   assign io_bus.done       = (r_state == StDone);

   // Controller state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Controller next-state: zero-length messages skip straight to completion
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle: begin
            if (io_bus.start) begin
               w_state_d = (io_bus.msg_len == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            if (w_fire && w_is_last) begin
               w_state_d = StDrain;
            end
         end
         StDrain: begin
            if (r_dout_valid && io_bus.dout_ready) begin
               w_state_d = StDone;
            end
         end
         StDone: begin
            w_state_d = StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   // Output register, word counter and per-message length bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= '0;
         r_nwords     <= '0;
         r_rem        <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_dout_last  <= 1'b0;
      end else begin
         if ((r_state == StIdle) && io_bus.start) begin
            r_cnt    <= '0;
            r_nwords <= w_nwords_new;
            r_rem    <= io_bus.msg_len[4:0];
         end
         if (w_fire) begin
            r_dout       <= w_out;
            r_dout_valid <= 1'b1;
            r_dout_last  <= w_is_last;
            r_cnt        <= r_cnt + CNT_W'(1);
         end else if (io_bus.dout_ready) begin
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
         end
      end
   end

endmodule
